sw_reporter: RTL and testbench

Upstream byte source for the UART transmit serializer in the switch/LED serial link. It synchronizes and debounces the board switches. When the debounced value changes, or a report is requested, it emits a 10-byte ASCII report: 8 characters `'0'`/`'1'` (sw[7] first), then CR, LF. Bytes go out one at a time through the serializer's tx_ready / tx_rd / tx_data handshake.

---
 rtl/sw_reporter.sv | 142 ++++++++++++++
 tb/tb_sw_reporter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_reporter.sv
// Switch reporter: synchronizes and debounces the board switches, then streams an ASCII
// snapshot ("bbbbbbbb\r\n", MSB first) to a UART serializer over a ready/read handshake.
module sw_reporter #(
    parameter int          SW_W    = 8,
    parameter logic [19:0] DEB_CNT = 20'd1_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SW_W-1:0] sw,
    input  logic            report_req,
    output logic            tx_ready,
    input  logic            tx_rd,
    output logic [7:0]      tx_data,
    output logic            busy
);

    localparam int IDX_W = $clog2(SW_W + 2);
    localparam logic [IDX_W-1:0] IDX_LASTBIT = IDX_W'(SW_W - 1);
    localparam logic [IDX_W-1:0] IDX_CR      = IDX_W'(SW_W);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(SW_W + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    logic [SW_W-1:0] sync1_q, sync2_q, cand_q, stable_q;
    logic [19:0]     cnt_q;
    logic [20:0]     run_len;
    logic            deb_fire;

    // run_len is how many cycles sw_sync has held its present value, so a new
    // level is accepted exactly DEB_CNT edges after it reaches sw_sync.
    always_comb begin
        run_len  = (sync2_q != cand_q) ? 21'd1 : ({1'b0, cnt_q} + 21'd2);
        deb_fire = (sync2_q != stable_q) && (run_len >= {1'b0, DEB_CNT});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q <= sw;
            sync2_q <= sync1_q;
            cand_q  <= sync2_q;
            if (deb_fire) begin
                stable_q <= sync2_q;
                cnt_q    <= '0;
            end else if (sync2_q != cand_q) begin
                cnt_q <= '0;
            end else if (cand_q != stable_q) begin
                cnt_q <= cnt_q + 20'd1;
            end
        end
    end

    state_t          state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [SW_W-1:0] snap_q, snap_d;
    logic [SW_W-1:0] last_q, last_d;
    logic            req_q, req_d;
    logic            tx_ready_q, tx_ready_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            busy_q, busy_d;

    // snap_q shifts left per accepted bit so the next character is always at SW_W-2
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        snap_d     = snap_q;
        last_d     = last_q;
        req_d      = req_q | report_req;
        tx_ready_d = tx_ready_q;
        tx_data_d  = tx_data_q;
        busy_d     = busy_q;
        case (state_q)
            S_IDLE: begin
                if ((stable_q != last_q) || req_q) begin
                    state_d    = S_SEND;
                    snap_d     = stable_q;
                    last_d     = stable_q;
                    req_d      = report_req;
                    idx_d      = '0;
                    tx_ready_d = 1'b1;
                    tx_data_d  = 8'h30 | {7'd0, stable_q[SW_W-1]};
                    busy_d     = 1'b1;
                end
            end
            S_SEND: begin
                if (tx_rd) begin
                    if (idx_q == IDX_LAST) begin
                        state_d    = S_IDLE;
                        tx_ready_d = 1'b0;
                        busy_d     = 1'b0;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        snap_d = snap_q << 1;
                        if (idx_q == IDX_LASTBIT) begin
                            tx_data_d = 8'h0D;
                        end else if (idx_q == IDX_CR) begin
                            tx_data_d = 8'h0A;
                        end else begin
                            tx_data_d = 8'h30 | {7'd0, snap_q[SW_W-2]};
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            snap_q     <= '0;
            last_q     <= '0;
            req_q      <= 1'b0;
            tx_ready_q <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            snap_q     <= snap_d;
            last_q     <= last_d;
            req_q      <= req_d;
            tx_ready_q <= tx_ready_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_sw_reporter.sv
// Bench for sw_reporter: a serializer model drives the handshake, and a message-level
// model predicts the ASCII byte stream for each reported switch value.
module tb_sw_reporter;

    localparam logic [19:0] DEB = 20'd4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sw;
    logic       report_req;
    logic       tx_ready;
    logic       tx_rd;
    logic [7:0] tx_data;
    logic       busy;

    sw_reporter #(.SW_W(8), .DEB_CNT(DEB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw         (sw),
        .report_req (report_req),
        .tx_ready   (tx_ready),
        .tx_rd      (tx_rd),
        .tx_data    (tx_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         ser_st = 0;
    int         gap = 0;
    logic [7:0] cap_byte = 8'h00;
    bit         tied = 1'b0;
    bit         saw_ready = 1'b0;
    bit         prev_busy = 1'b0;
    int         msg_rd = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void add_msg(input logic [7:0] v);
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(48 + ((v >> (7 - i)) & 8'd1)));
        exp_q.push_back(8'd13);
        exp_q.push_back(8'd10);
    endfunction

    task automatic check_msgs(input string tag);
        chk({tag, " byte_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) chk(tag, rx_q[i], exp_q[i]);
        rx_q.delete();
        exp_q.delete();
    endtask

    // One clock: serializer captures when idle and tx_ready, pulses tx_rd next cycle,
    // then stays busy for a random frame gap.
    task automatic step();
        if (busy && tx_rd) msg_rd++;
        if (tied && tx_ready) rx_q.push_back(tx_data);
        @(posedge clk);
        #1;
        if (tx_ready) saw_ready = 1'b1;
        if (!prev_busy && busy) msg_rd = 0;
        if (prev_busy && !busy) begin
            chk("busy_fall_ready", tx_ready, 0);
            chk("busy_fall_rd_count", msg_rd, 10);
        end
        prev_busy = busy;
        if (tied) begin
            tx_rd = 1'b1;
        end else begin
            case (ser_st)
                0: if (tx_ready) begin cap_byte = tx_data; ser_st = 1; end
                1: begin
                    chk("hold_data", tx_data, cap_byte);
                    rx_q.push_back(cap_byte);
                    tx_rd = 1'b1;
                    ser_st = 2;
                end
                2: begin
                    tx_rd = 1'b0;
                    gap = $urandom_range(0, 3);
                    ser_st = (gap == 0) ? 0 : 3;
                end
                default: begin
                    gap--;
                    if (gap <= 0) ser_st = 0;
                end
            endcase
        end
    endtask

    task automatic drain(input string tag);
        int quiet = 0;
        int n = 0;
        while (quiet < 12 && n < 3000) begin
            step();
            n++;
            if (!busy && !tx_ready && ser_st == 0 && !tx_rd) quiet++;
            else quiet = 0;
        end
        chk({tag, " drain"}, quiet, 12);
    endtask

    task automatic pulse_req();
        report_req = 1'b1;
        step();
        report_req = 1'b0;
    endtask

    task automatic wait_rd(input int n, input string tag);
        int k = 0;
        while (msg_rd < n && k < 500) begin
            step();
            k++;
        end
        chk(tag, msg_rd, n);
    endtask

    initial begin
        int n;
        logic [7:0] v, last_v;

        rst_n = 1'b0; sw = 8'h00; report_req = 1'b0; tx_rd = 1'b0;
        #23;
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_data", tx_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        saw_ready = 1'b0;
        for (int i = 0; i < 10 * int'(DEB); i++) step();
        chk("rst_no_report", saw_ready, 0);
        chk("rst_no_bytes", rx_q.size(), 0);

        // Basic report with latency measured from the first edge that samples the change
        sw = 8'hA5;
        n = 0;
        while (!tx_ready && n < 50) begin step(); n++; end
        chk("basic_latency", n, int'(DEB) + 3);
        drain("basic");
        add_msg(8'hA5);
        check_msgs("basic_msg");

        // Reset in the middle of a message
        msg_rd = 0;
        pulse_req();
        wait_rd(4, "rst_mid_wait");
        rst_n = 1'b0; tx_rd = 1'b0; ser_st = 0;
        #1;
        chk("rst_mid_tx_ready", tx_ready, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_tx_data", tx_data, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        prev_busy = 1'b0;
        rx_q.delete();
        drain("rst_mid");
        add_msg(8'hA5);
        check_msgs("rst_mid_msg");

        // Bounce on sw[0], then settle
        sw = 8'h00;
        drain("to_zero");
        add_msg(8'h00);
        check_msgs("to_zero_msg");
        for (int i = 0; i < 10; i++) begin
            sw[0] = ~sw[0];
            step();
            step();
        end
        sw = 8'h01;
        drain("bounce");
        add_msg(8'h01);
        check_msgs("bounce_msg");

        // Forced reports: one in idle, one during byte 3
        sw = 8'h3C;
        drain("set_3c");
        add_msg(8'h3C);
        check_msgs("set_3c_msg");
        msg_rd = 0;
        report_req = 1'b1;
        step();
        report_req = 1'b0;
        chk("req_lat_1", tx_ready, 0);
        step();
        chk("req_lat_2", tx_ready, 1);
        wait_rd(3, "forced_wait");
        pulse_req();
        drain("forced");
        add_msg(8'h3C);
        add_msg(8'h3C);
        check_msgs("forced_msgs");

        // Switch change while a message is in flight
        sw = 8'h01;
        drain("set_01");
        add_msg(8'h01);
        check_msgs("set_01_msg");
        msg_rd = 0;
        pulse_req();
        wait_rd(5, "midchg_wait");
        sw = 8'h02;
        drain("midchg");
        add_msg(8'h01);
        add_msg(8'h02);
        check_msgs("midchg_msgs");

        // Stray tx_rd while idle
        tx_rd = 1'b1;
        step();
        tx_rd = 1'b0;
        for (int i = 0; i < 15; i++) step();
        chk("stray_ready", tx_ready, 0);
        chk("stray_busy", busy, 0);
        chk("stray_data_kept", tx_data, 8'h0A);
        chk("stray_no_bytes", rx_q.size(), 0);

        // tx_rd tied high: one byte per cycle
        tied = 1'b1;
        tx_rd = 1'b1;
        pulse_req();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tx_ready) n++;
        end
        chk("tied_cycles", n, 10);
        chk("tied_idle", busy, 0);
        add_msg(8'h02);
        check_msgs("tied_msg");
        tied = 1'b0;
        tx_rd = 1'b0;
        step();

        // Random switch values
        last_v = 8'h02;
        for (int k = 0; k < 4; k++) begin
            v = 8'($urandom_range(0, 255));
            if (v == last_v) v = ~v;
            sw = v;
            drain("rand");
            add_msg(v);
            check_msgs("rand_msg");
            last_v = v;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
